boot_rom_gen: RTL

//   Parametrised boot ROM for the LnL SoC: a constant boot image plus a writable scratch

---
 rtl/boot_rom_pkg.sv | 29 ++
 rtl/boot_rom_patch.sv | 58 +++++
 rtl/boot_rom_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/boot_rom_pkg.sv
// Boot ROM package: default geometry, opcode encodings and the constant boot image.
// The patch-slot feature is enabled by defining BOOTROM_PATCH_EN.
package boot_rom_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 3;
    localparam int IMAGE_LEN = 7;

    localparam logic [3:0] OP_JMP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_LDI = 4'hF;

    function automatic logic [15:0] rom_word(input logic [31:0] addr);
        logic [15:0] w;
        case (addr)
            32'd0:   w = {OP_LDI, 12'h200};
            32'd1:   w = {OP_OUT, 12'h000};
            32'd2:   w = {OP_LDI, 12'h800};
            32'd3:   w = {OP_JMP, 12'h007};
            32'd4:   w = {OP_LDI, 12'h400};
            32'd5:   w = {OP_ADD, 12'h008};
            32'd6:   w = {OP_OUT, 12'h000};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/boot_rom_patch.sv
// Patch slots for the boot ROM: {valid, addr, data} per slot, lowest matching valid slot wins.
// Only instantiated when BOOTROM_PATCH_EN is defined.
module boot_rom_patch #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int PATCH_N = 2,
    parameter int SW      = (PATCH_N > 1) ? $clog2(PATCH_N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          patch_we,
    input  logic [SW-1:0] patch_sel,
    input  logic [AW-1:0] patch_addr,
    input  logic [DW-1:0] patch_data,
    input  logic          patch_clr,
    input  logic [AW-1:0] rd_addr,
    output logic          hit,
    output logic [DW-1:0] hit_data
);

    logic [PATCH_N-1:0] valid_r;
    logic [AW-1:0]      slot_addr_r [PATCH_N];
    logic [DW-1:0]      slot_data_r [PATCH_N];

    // Slot storage: clear has priority over load; out-of-range selects are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < PATCH_N; i++) begin
                slot_addr_r[i] <= '0;
                slot_data_r[i] <= '0;
            end
        end else if (patch_clr) begin
            valid_r <= '0;
        end else if (patch_we && (int'(patch_sel) < PATCH_N)) begin
            valid_r[patch_sel]     <= 1'b1;
            slot_addr_r[patch_sel] <= patch_addr;
            slot_data_r[patch_sel] <= patch_data;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Priority match: scan downward so the lowest index overwrites higher ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = PATCH_N - 1; i >= 0; i--) begin
            if (valid_r[i] && (slot_addr_r[i] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = slot_data_r[i];
            end else begin
                hit      = hit;
            end
        end
    end

endmodule

// File: rtl/boot_rom_gen.sv
// Boot ROM with writable scratch words at the top of the address space, 1-cycle registered reads.
// Define BOOTROM_PATCH_EN to add the patch-slot ports and override logic.
module boot_rom_gen
    import boot_rom_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int RW_WORDS = 1,
    parameter int PATCH_N  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          ack,
    output logic          err
`ifdef BOOTROM_PATCH_EN
    ,
    input  logic                                          patch_we,
    input  logic [((PATCH_N > 1) ? $clog2(PATCH_N) : 1)-1:0] patch_sel,
    input  logic [AW-1:0]                                 patch_addr,
    input  logic [DW-1:0]                                 patch_data,
    input  logic                                          patch_clr
`endif
);

    localparam int DEPTH     = 2 ** AW;
    localparam int ROM_WORDS = DEPTH - RW_WORDS;

    logic [DW-1:0] scratch_r [DEPTH];
    logic [DW-1:0] dout_r;
    logic          ack_r;
    logic          err_r;
    logic          is_rom_s;
    logic [DW-1:0] rd_data_s;
    logic          patch_hit_s;
    logic [DW-1:0] patch_data_s;

`ifdef BOOTROM_PATCH_EN
    boot_rom_patch #(
        .DW      (DW),
        .AW      (AW),
        .PATCH_N (PATCH_N)
    ) u_patch (
        .clk        (clk),
        .rst        (rst),
        .patch_we   (patch_we),
        .patch_sel  (patch_sel),
        .patch_addr (patch_addr),
        .patch_data (patch_data),
        .patch_clr  (patch_clr),
        .rd_addr    (addr),
        .hit        (patch_hit_s),
        .hit_data   (patch_data_s)
    );
`else
    assign patch_hit_s  = 1'b0;
    assign patch_data_s = '0;
`endif

    // Region decode and read mux: patch overrides ROM and scratch.
    always_comb begin
        is_rom_s  = (int'(addr) < ROM_WORDS);
        rd_data_s = '0;
        if (patch_hit_s) begin
            rd_data_s = patch_data_s;
        end else if (is_rom_s) begin
            rd_data_s = DW'(rom_word(32'(addr)));
        end else begin
            rd_data_s = scratch_r[addr];
        end
    end

    // Access registers: dout only moves on reads, ack/err are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                scratch_r[i] <= '0;
            end
        end else begin
            ack_r <= cs;
            err_r <= cs & we & is_rom_s;
            if (cs && !we) begin
                dout_r <= rd_data_s;
            end else begin
                dout_r <= dout_r;
            end
            if (cs && we && !is_rom_s) begin
                scratch_r[addr] <= din;
            end else begin
                scratch_r[addr] <= scratch_r[addr];
            end
        end
    end

    assign dout = dout_r;
    assign ack  = ack_r;
    assign err  = err_r;

endmodule
